// File: rtl/ads1256_scan_ctrl.sv
// rtl/ads1256_scan_ctrl.sv - ADS1256 init and round-robin channel scan sequencer over a 24-bit SPI frame driver
// Optional DRDY watchdog: define ADS1256_TIMEOUT_EN (adds parameter TIMEOUT_CYC).
module ads1256_scan_ctrl #(
  parameter int NUM_CH     = 8,
  parameter int T6_CYCLES  = 64,
  parameter int T11_CYCLES = 32
`ifdef ADS1256_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 2**22
`endif
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  adcon_cfg,
  input  logic [7:0]  drate_cfg,
  input  logic        adc_drdy_n,
  output logic        adc_cs_n,
  output logic        spi_start,
  output logic [23:0] spi_wr_data,
  input  logic [23:0] spi_rd_data,
  input  logic        spi_done,
  output logic [23:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [4:0] {
    IDLE, I_ADCON, I_DRATE, I_MUX, I_GAP1, I_SYNC, I_GAP2, I_WAKE,
    WAIT_DRDY, RDCMD, T6_GAP, RDDAT, WRMUX, S_GAP1, S_SYNC, S_GAP2, S_WAKE
  } state_t;

  localparam int GAP_MAX = (T6_CYCLES > T11_CYCLES) ? T6_CYCLES : T11_CYCLES;
  localparam int CW = $clog2(GAP_MAX + 1);
  localparam logic [CW-1:0] T6_LAST  = CW'(T6_CYCLES - 1);
  localparam logic [CW-1:0] T11_LAST = CW'(T11_CYCLES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] gap_cnt;
  logic          frame_gap;
  logic          frame;
  logic          drdy_meta, drdy_sync, drdy_prev, drdy_fall;
  logic [2:0]    cur_ch, nxt_ch;
  logic          first_flag;
  logic [7:0]    adcon_q, drate_q;
  logic          enter_init;

`ifdef ADS1256_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        to_hit;
  assign to_hit = (state == WAIT_DRDY) && enable && !drdy_fall &&
                  (to_cnt == 32'(TIMEOUT_CYC - 1));
`endif

  assign drdy_fall  = drdy_prev & ~drdy_sync;
  assign nxt_ch     = (cur_ch == 3'(NUM_CH - 1)) ? 3'd0 : cur_ch + 3'd1;
  assign enter_init = (state_nx == I_ADCON) && (state != I_ADCON);
  assign busy       = (state != IDLE);
  assign adc_cs_n   = (state == IDLE) || (state == WAIT_DRDY);

  always_comb begin
    state_nx    = state;
    frame       = 1'b0;
    spi_wr_data = 24'h000000;
    case (state)
      IDLE:    if (enable) state_nx = I_ADCON;
      I_ADCON: begin
        frame = 1'b1; spi_wr_data = {8'h52, 8'h00, adcon_q};
        if (spi_done) state_nx = I_DRATE;
      end
      I_DRATE: begin
        frame = 1'b1; spi_wr_data = {8'h53, 8'h00, drate_q};
        if (spi_done) state_nx = I_MUX;
      end
      I_MUX: begin
        frame = 1'b1; spi_wr_data = {8'h51, 8'h00, 8'h08};
        if (spi_done) state_nx = I_GAP1;
      end
      I_GAP1:  if (gap_cnt == T11_LAST) state_nx = I_SYNC;
      I_SYNC: begin
        frame = 1'b1; spi_wr_data = 24'h0000FC;
        if (spi_done) state_nx = I_GAP2;
      end
      I_GAP2:  if (gap_cnt == T11_LAST) state_nx = I_WAKE;
      I_WAKE: begin
        frame = 1'b1;
        if (spi_done) state_nx = WAIT_DRDY;
      end
      WAIT_DRDY: begin
        // enable has priority so a stop request is never delayed by a pending conversion
        if (!enable) state_nx = IDLE;
        else if (drdy_fall) state_nx = RDCMD;
`ifdef ADS1256_TIMEOUT_EN
        else if (to_hit) state_nx = I_ADCON;
`endif
      end
      RDCMD: begin
        frame = 1'b1; spi_wr_data = 24'h000001;
        if (spi_done) state_nx = T6_GAP;
      end
      T6_GAP:  if (gap_cnt == T6_LAST) state_nx = RDDAT;
      RDDAT: begin
        frame = 1'b1;
        if (spi_done) state_nx = WRMUX;
      end
      WRMUX: begin
        frame = 1'b1; spi_wr_data = {8'h51, 8'h00, 1'b0, nxt_ch, 4'h8};
        if (spi_done) state_nx = S_GAP1;
      end
      S_GAP1:  if (gap_cnt == T11_LAST) state_nx = S_SYNC;
      S_SYNC: begin
        frame = 1'b1; spi_wr_data = 24'h0000FC;
        if (spi_done) state_nx = S_GAP2;
      end
      S_GAP2:  if (gap_cnt == T11_LAST) state_nx = S_WAKE;
      S_WAKE: begin
        frame = 1'b1;
        if (spi_done) state_nx = WAIT_DRDY;
      end
      default: state_nx = IDLE;
    endcase
    // one low cycle after every completed frame separates back-to-back frames
    spi_start = frame && !frame_gap;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      frame_gap    <= 1'b0;
      drdy_meta    <= 1'b1;
      drdy_sync    <= 1'b1;
      drdy_prev    <= 1'b1;
      cur_ch       <= 3'd0;
      first_flag   <= 1'b1;
      adcon_q      <= 8'h00;
      drate_q      <= 8'h00;
      sample_data  <= 24'h000000;
      sample_ch    <= 3'd0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      gap_cnt      <= (state_nx != state) ? '0 : gap_cnt + CW'(1);
      frame_gap    <= spi_done & spi_start;
      drdy_meta    <= adc_drdy_n;
      drdy_sync    <= drdy_meta;
      drdy_prev    <= drdy_sync;
      sample_valid <= 1'b0;
      if (enter_init) begin
        cur_ch     <= 3'd0;
        first_flag <= 1'b1;
        adcon_q    <= adcon_cfg;
        drate_q    <= drate_cfg;
      end
      if (state == RDDAT && spi_done) begin
        sample_data  <= spi_rd_data;
        sample_ch    <= cur_ch;
        sample_valid <= !first_flag;
        first_flag   <= 1'b0;
      end
      // the MUX written in this service takes effect for the next conversion
      if (state == S_WAKE && spi_done) cur_ch <= nxt_ch;
    end
  end

`ifdef ADS1256_TIMEOUT_EN
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      to_cnt      <= 32'd0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_DRDY && state_nx == WAIT_DRDY) ? to_cnt + 32'd1 : 32'd0;
      if (to_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ads1256_scan_ctrl.sv
// tb/tb_ads1256_scan_ctrl.sv - directed bench for ads1256_scan_ctrl with an SPI frame driver model
// Timeout section runs only when ADS1256_TIMEOUT_EN is defined.
module tb_ads1256_scan_ctrl;

  localparam int NUM_CH    = 3;
  localparam int T6        = 64;
  localparam int T11       = 32;
  localparam int FRAME_LAT = 24;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  adcon_cfg, drate_cfg;
  logic        adc_drdy_n;
  logic        adc_cs_n, spi_start, spi_done, sample_valid, busy, timeout_err;
  logic [23:0] spi_wr_data, spi_rd_data, sample_data;
  logic [2:0]  sample_ch;

  ads1256_scan_ctrl #(
    .NUM_CH(NUM_CH), .T6_CYCLES(T6), .T11_CYCLES(T11)
`ifdef ADS1256_TIMEOUT_EN
    , .TIMEOUT_CYC(1000)
`endif
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .adcon_cfg(adcon_cfg),
    .drate_cfg(drate_cfg), .adc_drdy_n(adc_drdy_n), .adc_cs_n(adc_cs_n),
    .spi_start(spi_start), .spi_wr_data(spi_wr_data), .spi_rd_data(spi_rd_data),
    .spi_done(spi_done), .sample_data(sample_data), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI driver model: frame log, fixed latency, RDATA reply from the channel last programmed
  logic [23:0] fr_data [0:255];
  int          fr_start[0:255];
  int          fr_done [0:255];
  int          fr_n = 0, drv_cnt = 0, last_rddat = -1, rddat_done = -10;
  int          cs_bad = 0, wr_unstable = 0;
  logic        armed = 1'b1;
  logic [2:0]  mux_ch = 3'd0;
  logic [23:0] reply = 24'h0;
  logic [23:0] ch_data [0:2];

  initial begin
    ch_data[0] = 24'h123456; ch_data[1] = 24'h800000; ch_data[2] = 24'h7FFFFF;
    spi_done = 1'b0; spi_rd_data = 24'h0;
    forever begin
      @(negedge sys_clk);
      spi_done = 1'b0;
      if (!rst_n) begin
        drv_cnt = 0; armed = 1'b1;
      end else begin
        if (!spi_start) armed = 1'b1;
        if (drv_cnt > 0) begin
          drv_cnt--;
          if (spi_wr_data !== fr_data[fr_n-1]) wr_unstable++;
          if (drv_cnt == 0) begin
            spi_done = 1'b1; spi_rd_data = reply; fr_done[fr_n-1] = cyc;
            if (fr_n - 1 == last_rddat) rddat_done = cyc;
          end
        end else if (spi_start && armed && fr_n < 256) begin
          armed = 1'b0;
          if (adc_cs_n !== 1'b0) cs_bad++;
          fr_data[fr_n] = spi_wr_data; fr_start[fr_n] = cyc;
          reply = 24'h0;
          if (spi_wr_data[23:16] == 8'h51) mux_ch = spi_wr_data[6:4];
          if (fr_n > 0 && spi_wr_data == 24'h0 && fr_data[fr_n-1] == 24'h000001) begin
            reply = ch_data[mux_ch]; last_rddat = fr_n;
          end
          fr_n++;
          drv_cnt = FRAME_LAT;
        end
      end
    end
  end

  logic [23:0] s_data [0:63];
  logic [2:0]  s_ch   [0:63];
  int          s_n = 0, long_sv = 0, late_sv = 0;
  logic        prev_sv = 1'b0;

  initial forever begin
    @(negedge sys_clk);
    if (sample_valid === 1'b1 && s_n < 64) begin
      if (prev_sv) long_sv++;
      if (cyc != rddat_done + 1) late_sv++;
      s_data[s_n] = sample_data; s_ch[s_n] = sample_ch; s_n++;
    end
    prev_sv = sample_valid;
  end

  task automatic wait_frames(input int target, input int budget, input string tag);
    int k = 0;
    while (fr_n < target && k < budget) begin
      @(negedge sys_clk); k++;
    end
    check_val(tag, fr_n, target);
  endtask

  task automatic drdy_pulse();
    adc_drdy_n = 1'b0;
    repeat (4) @(negedge sys_clk);
    adc_drdy_n = 1'b1;
  endtask

  task automatic one_service(input string tag);
    int base = fr_n;
    drdy_pulse();
    wait_frames(base + 5, 1000, tag);
    repeat (40) @(negedge sys_clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base, s0;
  logic [23:0] exp_data [0:3];
  logic [2:0]  exp_ch   [0:3];

  initial begin
    exp_data[0] = 24'h800000; exp_ch[0] = 3'd1;
    exp_data[1] = 24'h7FFFFF; exp_ch[1] = 3'd2;
    exp_data[2] = 24'h123456; exp_ch[2] = 3'd0;
    exp_data[3] = 24'h800000; exp_ch[3] = 3'd1;
    rst_n = 1'b0; enable = 1'b0; adcon_cfg = 8'h20; drate_cfg = 8'hF0; adc_drdy_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_val("rst_cs_n", adc_cs_n, 1);
    check_val("rst_start", spi_start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_valid", sample_valid, 0);
    check_val("rst_data", sample_data, 0);
    check_val("rst_ch", sample_ch, 0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // init sequence
    enable = 1'b1;
    wait_frames(5, 2000, "init_frames");
    repeat (40) @(negedge sys_clk);
    check_val("init_adcon", fr_data[0], 24'h520020);
    check_val("init_drate", fr_data[1], 24'h5300F0);
    check_val("init_mux", fr_data[2], 24'h510008);
    check_val("init_sync", fr_data[3], 24'h0000FC);
    check_val("init_wake", fr_data[4], 24'h000000);
    check_val("init_t11_a", fr_start[3] - fr_done[2], T11 + 1);
    check_val("init_t11_b", fr_start[4] - fr_done[3], T11 + 1);
    check_val("wait_cs_n", adc_cs_n, 1);
    check_val("wait_busy", busy, 1);

    // five services: first conversion dropped, then channels 1,2,0,1
    for (int i = 0; i < 5; i++) one_service($sformatf("svc%0d_frames", i));
    check_val("svc_rdcmd", fr_data[5], 24'h000001);
    check_val("svc_rddat", fr_data[6], 24'h000000);
    check_val("svc_mux1", fr_data[7], 24'h510018);
    check_val("svc_sync", fr_data[8], 24'h0000FC);
    check_val("svc_wake", fr_data[9], 24'h000000);
    check_val("svc_mux2", fr_data[12], 24'h510028);
    check_val("svc_mux_wrap", fr_data[17], 24'h510008);
    check_val("t6_gap", fr_start[6] - fr_done[5], T6 + 1);
    check_val("t11_mux_sync", fr_start[8] - fr_done[7], T11 + 1);
    check_val("t11_sync_wake", fr_start[9] - fr_done[8], T11 + 1);
    check_val("scan_count", s_n, 4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("scan_ch%0d", i), s_ch[i], exp_ch[i]);
      check_val($sformatf("scan_data%0d", i), s_data[i], exp_data[i]);
    end

    // DRDY falling during RDDAT is not queued
    base = fr_n; s0 = s_n;
    drdy_pulse();
    wait_frames(base + 2, 1000, "rddat_reach");
    repeat (3) @(negedge sys_clk);
    drdy_pulse();
    repeat (400) @(negedge sys_clk);
    check_val("rddat_drdy_frames", fr_n - base, 5);
    check_val("rddat_drdy_samples", s_n - s0, 1);

    // DRDY held low on return to WAIT_DRDY does not retrigger
    base = fr_n; s0 = s_n;
    adc_drdy_n = 1'b0;
    repeat (400) @(negedge sys_clk);
    check_val("held_low_frames", fr_n - base, 5);
    check_val("held_low_samples", s_n - s0, 1);
    adc_drdy_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // enable dropped during T6: sequence completes, then IDLE
    base = fr_n; s0 = s_n;
    drdy_pulse();
    wait_frames(base + 1, 1000, "t6_reach");
    repeat (FRAME_LAT + 10) @(negedge sys_clk);
    enable = 1'b0;
    repeat (400) @(negedge sys_clk);
    check_val("dis_frames", fr_n - base, 5);
    check_val("dis_samples", s_n - s0, 1);
    check_val("dis_busy", busy, 0);
    check_val("dis_cs_n", adc_cs_n, 1);

    // re-init samples new config, resets channel and drops first conversion
    base = fr_n; s0 = s_n;
    adcon_cfg = 8'h31;
    enable = 1'b1;
    wait_frames(base + 5, 2000, "reinit_frames");
    repeat (40) @(negedge sys_clk);
    check_val("reinit_adcon", fr_data[base], 24'h520031);
    base = fr_n;
    one_service("reinit_svc");
    check_val("reinit_mux", fr_data[base + 2], 24'h510018);
    check_val("reinit_drop", s_n - s0, 0);

    // reset during RDDAT
    base = fr_n; s0 = s_n;
    drdy_pulse();
    wait_frames(base + 2, 1000, "rst_rddat_reach");
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b0; enable = 1'b0;
    @(negedge sys_clk);
    check_val("midrst_start", spi_start, 0);
    check_val("midrst_cs_n", adc_cs_n, 1);
    check_val("midrst_busy", busy, 0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (60) @(negedge sys_clk);
    check_val("midrst_no_sample", s_n - s0, 0);

`ifdef ADS1256_TIMEOUT_EN
    base = fr_n;
    enable = 1'b1;
    wait_frames(base + 5, 2000, "to_init_frames");
    begin
      int k = 0;
      while (timeout_err !== 1'b1 && k < 1200) begin
        @(negedge sys_clk); k++;
      end
    end
    check_val("timeout_err", timeout_err, 1);
    wait_frames(base + 6, 100, "to_reinit_frame");
    check_val("to_reinit_adcon", fr_data[base + 5], 24'h520031);
`else
    check_val("timeout_off", timeout_err, 0);
`endif

    check_val("cs_low_in_frames", cs_bad, 0);
    check_val("wr_data_stable", wr_unstable, 0);
    check_val("valid_one_cycle", long_sv, 0);
    check_val("valid_latency", late_sv, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
